freq_gate_count_module: RTL



---
 rtl/freq_meter_pkg.sv | 37 +++
 rtl/signal_sync_edge_module.sv | 33 +++
 rtl/freq_gate_count_module.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and elaboration helpers for the frequency meter blocks.
// Users: freq_gate_count_module, signal_sync_edge_module.
package freq_meter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      GATE,
      CALC,
      DONE
   } state_e;

   // Headroom for the constant-multiply step of the scaled result.
   localparam int CALC_EXT_W = 32;

   function automatic int log2_of(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) <= v) r = i;
      end
      return r;
   endfunction

   function automatic int scale_of(input int clk_hz, input int gate);
      return clk_hz / gate;
   endfunction

   function automatic int gate_cnt_w(input int gate);
      return (gate <= 2) ? 1 : $clog2(gate);
   endfunction

   function automatic logic [63:0] sat_limit(input int w);
      return {64{1'b1}} >> (64 - w);
   endfunction

endpackage

// File: rtl/signal_sync_edge_module.sv
// Two-flop synchronizer plus a third flop for rising-edge detection.
// Reusable by any block sampling an asynchronous pulse train.
module signal_sync_edge_module (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic rise
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = d_in;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/freq_gate_count_module.sv
// Gated edge counter for the prescaled signal; scales the count to Hz.
// FREQ_AUTO_RESTART_EN: re-arm after every result for continuous measurement.
module freq_gate_count_module
   import freq_meter_pkg::*;
#(
   parameter int CLK_HZ      = 50000000,
   parameter int GATE_CYCLES = 50000000,
   parameter int PRESCALE    = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             signal_in1,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] freq_out,
   output logic             overflow,
   output logic             timeout
);

   localparam int P_LOG2 = log2_of(PRESCALE);
   localparam int SCALE  = scale_of(CLK_HZ, GATE_CYCLES);
   localparam int GC_W   = gate_cnt_w(GATE_CYCLES);
   localparam int RES_W  = CNT_W + P_LOG2 + CALC_EXT_W;

   localparam logic [GC_W-1:0]  GC_LAST = GC_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_limit(CNT_W));
   localparam logic [RES_W-1:0] SCALE_R = RES_W'(SCALE);

   state_e           state_q, state_d;
   logic [GC_W-1:0]  gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] freq_q, freq_d;
   logic             ovf_out_q, ovf_out_d;
   logic             tmo_q, tmo_d;
   logic             rise;
   logic [RES_W-1:0] res;
   logic             res_sat;

   signal_sync_edge_module u_sync (
      .clk  (clk),
      .rst  (rst),
      .d_in (signal_in1),
      .rise (rise)
   );

   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      ovf_d      = ovf_q;
      freq_d     = freq_q;
      ovf_out_d  = ovf_out_q;
      tmo_d      = tmo_q;
      res        = (RES_W'(edge_cnt_q) << P_LOG2) * SCALE_R;
      res_sat    = |res[RES_W-1:CNT_W];
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = ARM;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               ovf_d      = 1'b0;
            end
         end
         ARM: begin
            // The arming edge only opens the window; it is not counted.
            if (rise) begin
               state_d    = GATE;
               gate_cnt_d = '0;
            end else if (gate_cnt_q == GC_LAST) begin
               state_d   = DONE;
               freq_d    = '0;
               ovf_out_d = 1'b0;
               tmo_d     = 1'b1;
            end else begin
               gate_cnt_d = gate_cnt_q + GC_W'(1);
            end
         end
         GATE: begin
            if (rise) begin
               if (edge_cnt_q == CNT_MAX) ovf_d = 1'b1;
               else edge_cnt_d = edge_cnt_q + CNT_W'(1);
            end
            if (gate_cnt_q == GC_LAST) state_d = CALC;
            else gate_cnt_d = gate_cnt_q + GC_W'(1);
         end
         CALC: begin
            state_d   = DONE;
            freq_d    = res_sat ? CNT_MAX : res[CNT_W-1:0];
            ovf_out_d = ovf_q | res_sat;
            tmo_d     = 1'b0;
         end
         DONE: begin
`ifdef FREQ_AUTO_RESTART_EN
            state_d    = ARM;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         ovf_q      <= 1'b0;
         freq_q     <= '0;
         ovf_out_q  <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         ovf_q      <= ovf_d;
         freq_q     <= freq_d;
         ovf_out_q  <= ovf_out_d;
         tmo_q      <= tmo_d;
      end
   end

`ifdef FREQ_AUTO_RESTART_EN
   assign busy = (state_q != IDLE);
`else
   assign busy = (state_q == ARM) || (state_q == GATE) || (state_q == CALC);
`endif
   assign done     = (state_q == DONE);
   assign freq_out = freq_q;
   assign overflow = ovf_out_q;
   assign timeout  = tmo_q;

endmodule
